// File: rtl/apb2wb_pkg.sv
// apb2wb_pkg: shared FSM state encoding and Wishbone termination priority for apb_to_wb.
package apb2wb_pkg;

   typedef enum logic [1:0] {IDLE, WB_REQ, WB_RTY, APB_RESP} state_t;

   // Enum values rise with priority: err_i beats ack_i beats rty_i.
   typedef enum logic [1:0] {TERM_NONE, TERM_RTY, TERM_ACK, TERM_ERR} term_t;

   function automatic term_t wb_term(input logic ack, input logic err, input logic rty);
      return err ? TERM_ERR : ack ? TERM_ACK : rty ? TERM_RTY : TERM_NONE;
   endfunction

endpackage

// File: rtl/apb_to_wb_if.sv
// apb_to_wb_if: APB slave port and Wishbone classic master port of the bridge.
interface apb_to_wb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] paddr;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [STRB_WIDTH-1:0] pstrb;
   logic                  pready;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pslverr;

   logic [ADDR_WIDTH-1:0] adr_o;
   logic [DATA_WIDTH-1:0] dat_o;
   logic [STRB_WIDTH-1:0] sel_o;
   logic                  we_o;
   logic                  cyc_o;
   logic                  stb_o;
   logic [DATA_WIDTH-1:0] dat_i;
   logic                  ack_i;
   logic                  err_i;
   logic                  rty_i;

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb, dat_i, ack_i, err_i, rty_i,
      output pready, prdata, pslverr, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o
   );

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb, dat_i, ack_i, err_i, rty_i,
      input  pready, prdata, pslverr, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o
   );

endinterface

// File: rtl/apb2wb_timer.sv
// apb2wb_timer: Wishbone termination watchdog; expired pulses on the TIMEOUT-th
// consecutive enabled cycle since the last clear.
module apb2wb_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + W'(1);

   assign expired = en && cnt == LAST;

endmodule

// File: rtl/apb_to_wb.sv
// apb_to_wb: APB slave to Wishbone classic master bridge with bounded retry.
// Optional Wishbone termination timeout is built when APB2WB_TIMEOUT_EN is defined.
module apb_to_wb
   import apb2wb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int RETRY_MAX  = 3,
   parameter int TIMEOUT    = 255
) (
   input logic        pclk,
   input logic        preset_n,
   apb_to_wb_if.slave bus
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int RW = $clog2(RETRY_MAX + 2);
   localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);

   if (RETRY_MAX < 0 || TIMEOUT < 1) begin : g_param_check
      $error("apb_to_wb: RETRY_MAX must be >= 0 and TIMEOUT >= 1");
   end

   state_t                state;
   term_t                 term;
   logic [RW-1:0]         rcnt;
   logic                  abandon, start, lost, fin, tmo;
   logic [ADDR_WIDTH-1:0] adr;
   logic [DATA_WIDTH-1:0] dat, prdata;
   logic [SW-1:0]         sel;
   logic                  we, cyc, stb, pready, pslverr;

   always_comb begin
      term  = wb_term(bus.ack_i, bus.err_i, bus.rty_i);
      start = state == IDLE && bus.psel && !bus.penable;
      lost  = abandon || !bus.psel;
      fin   = term == TERM_ERR || term == TERM_ACK || tmo || (term == TERM_RTY && rcnt == RMAX);
   end

`ifdef APB2WB_TIMEOUT_EN
   logic issue;
   assign issue = (start && !(bus.pwrite && bus.pstrb == '0)) || state == WB_RTY;
   apb2wb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (pclk),
      .rst_n   (preset_n),
      .clr     (issue),
      .en      (state == WB_REQ && term == TERM_NONE),
      .expired (tmo)
   );
`else
   assign tmo = 1'b0;
`endif

   // A transfer whose psel dropped early still finishes on Wishbone, but its result is dropped.
   always_ff @(posedge pclk or negedge preset_n)
      if (!preset_n) begin
         state   <= IDLE;
         rcnt    <= '0;
         abandon <= 1'b0;
         adr     <= '0;
         dat     <= '0;
         sel     <= '0;
         we      <= 1'b0;
         cyc     <= 1'b0;
         stb     <= 1'b0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= '0;
      end else
         case (state)
            IDLE:
               if (start) begin
                  adr     <= bus.paddr;
                  dat     <= bus.pwdata;
                  we      <= bus.pwrite;
                  sel     <= bus.pwrite ? bus.pstrb : '1;
                  rcnt    <= '0;
                  abandon <= 1'b0;
                  if (bus.pwrite && bus.pstrb == '0) begin
                     pready  <= 1'b1;
                     pslverr <= 1'b0;
                     state   <= APB_RESP;
                  end else begin
                     cyc   <= 1'b1;
                     stb   <= 1'b1;
                     state <= WB_REQ;
                  end
               end
            WB_REQ: begin
               abandon <= lost;
               if (fin) begin
                  cyc    <= 1'b0;
                  stb    <= 1'b0;
                  pready <= !lost;
                  state  <= lost ? IDLE : APB_RESP;
                  if (!lost) begin
                     pslverr <= term != TERM_ACK;
                     prdata  <= term != TERM_ACK ? '0 : we ? prdata : bus.dat_i;
                  end
               end else if (term == TERM_RTY) begin
                  stb   <= 1'b0;
                  rcnt  <= rcnt + RW'(1);
                  state <= WB_RTY;
               end
            end
            WB_RTY: begin
               abandon <= lost;
               stb     <= 1'b1;
               state   <= WB_REQ;
            end
            APB_RESP: begin
               pready <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase

   assign bus.adr_o   = adr;
   assign bus.dat_o   = dat;
   assign bus.sel_o   = sel;
   assign bus.we_o    = we;
   assign bus.cyc_o   = cyc;
   assign bus.stb_o   = stb;
   assign bus.pready  = pready;
   assign bus.pslverr = pslverr;
   assign bus.prdata  = prdata;

endmodule

// File: doc/apb_to_wb.md
APB_TO_WB -- requirements
Module: apb_to_wb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of paddr/adr_o.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of pwdata/prdata/dat_o/dat_i; strobe width = DATA_WIDTH/8.
REQ-003 SHALL have parameter RETRY_MAX, default 3, max Wishbone reissues after rty_i before error.
REQ-004 SHALL have parameter TIMEOUT, default 255, max pclk cycles waiting for a Wishbone termination.
REQ-005 SHALL have port pclk  input  1  single clock for both APB and Wishbone sides.
REQ-006 SHALL have port preset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port paddr  input  ADDR_WIDTH  APB address.
REQ-008 SHALL have port psel  input  1  APB select.
REQ-009 SHALL have port penable  input  1  APB access phase.
REQ-010 SHALL have port pwrite  input  1  APB direction, 1 = write.
REQ-011 SHALL have port pwdata  input  DATA_WIDTH  APB write data.
REQ-012 SHALL have port pstrb  input  DATA_WIDTH/8  APB byte strobes.
REQ-013 SHALL have port pready  output  1  APB transfer complete.
REQ-014 SHALL have port prdata  output  DATA_WIDTH  APB read data.
REQ-015 SHALL have port pslverr  output  1  APB error response.
REQ-016 SHALL have port adr_o  output  ADDR_WIDTH  Wishbone address.
REQ-017 SHALL have port dat_o  output  DATA_WIDTH  Wishbone write data.
REQ-018 SHALL have port sel_o  output  DATA_WIDTH/8  Wishbone byte selects.
REQ-019 SHALL have port we_o  output  1  Wishbone write enable.
REQ-020 SHALL have port cyc_o  output  1  Wishbone cycle.
REQ-021 SHALL have port stb_o  output  1  Wishbone strobe.
REQ-022 SHALL have port dat_i  input  DATA_WIDTH  Wishbone read data.
REQ-023 SHALL have port ack_i  input  1  Wishbone acknowledge.
REQ-024 SHALL have port err_i  input  1  Wishbone error.
REQ-025 SHALL have port rty_i  input  1  Wishbone retry.

Function
REQ-026 SHALL implement FSM states IDLE, WB_REQ, WB_RTY, APB_RESP, all outputs registered; Wishbone classic cycles only.
REQ-027 IDLE: psel=1 & penable=0 sampled -> capture paddr/pwdata/pwrite; sel_o = pstrb on write, all-ones on read; cyc_o=stb_o=1 next cycle; go WB_REQ.
REQ-028 Write with pstrb=0: no Wishbone cycle; go directly to APB_RESP with pslverr=0.
REQ-029 WB_REQ termination priority err_i > ack_i > rty_i; ack/err -> cyc_o=stb_o=0, go APB_RESP; prdata <= dat_i on read ack, 0 on err.
REQ-030 rty_i with retry count < RETRY_MAX -> stb_o=0, cyc_o held 1, one cycle in WB_RTY, reissue stb_o; count exhausted -> drop cycle, APB_RESP with pslverr=1.
REQ-031 APB_RESP: pready=1 for exactly one cycle with pslverr; return IDLE; minimum APB access phase = 2 penable cycles (zero-wait Wishbone slave).
REQ-032 pready SHALL be 0 in all states except APB_RESP; prdata held until next response.
REQ-033 psel dropping before APB_RESP (protocol violation): outstanding Wishbone cycle completes normally, response discarded, return IDLE.
REQ-034 ack_i/err_i/rty_i outside WB_REQ SHALL be ignored; retry counter cleared on every new APB transfer.

Reset
REQ-035 preset_n=0 SHALL asynchronously force IDLE and all outputs to 0 (cyc_o drops mid-cycle), clear retry and timeout counters.

Configuration
REQ-036 With APB2WB_TIMEOUT_EN defined: counter reset on each stb_o issue; TIMEOUT cycles in WB_REQ with no termination -> drop cyc_o/stb_o, APB_RESP with pslverr=1, prdata=0.
REQ-037 Without APB2WB_TIMEOUT_EN: no counter logic; WB_REQ waits indefinitely.

Structure
REQ-038 Package apb2wb_pkg SHALL hold the state enum and WB termination priority constants.
REQ-039 Timeout counter SHALL be sub-module apb2wb_timer, instantiated only under APB2WB_TIMEOUT_EN.

Verification
REQ-040 Write paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF, ack_i next cycle -> adr_o=0x10, dat_o=0xDEADBEEF, sel_o=0xF, we_o=1; pready=1, pslverr=0 for one cycle.
REQ-041 Read paddr=0x20, ack_i with dat_i=0x12345678 after 3 wait cycles -> prdata=0x12345678, pready after 3 extra cycles, sel_o=0xF.
REQ-042 rty_i on 4 consecutive issues (RETRY_MAX=3) -> 4 stb_o pulses, cyc_o held, then pready=1, pslverr=1.
REQ-043 err_i and ack_i same cycle -> pslverr=1, prdata=0; write with pstrb=0 -> pready, no cyc_o.
REQ-044 APB2WB_TIMEOUT_EN, TIMEOUT=8, no termination -> cyc_o drops after 8 cycles, pslverr=1; preset_n low mid-cycle -> all outputs 0 immediately.
